compute_cluster_sequencer: RTL and testbench

- Sequences one Compute_Cluster tile: loads IFM and filter chunks into the cluster's ping-pong chunk banks, launches a compute pass per chunk, waits for completion, then steps the per-CU output buffer readout.
- Overlaps the load of chunk k+1 (write bank) with compute of chunk k (read bank).
- Sits between the layer DMA/stream sources and the cluster's write, run and readout inputs.

---
 rtl/compute_cluster_sequencer.sv | 244 ++++++++++++++++++++++++
 tb/tb_compute_cluster_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/compute_cluster_sequencer.sv
// compute_cluster_sequencer
//   Sequences one Compute_Cluster tile. Chunks are loaded (IFM beats, then
//   filter beats per CU) into a ping-pong bank pair. Each loaded chunk is then
//   computed, and once every chunk is done the per-CU output buffers are
//   stepped out. While chunk k computes from the read bank, chunk k+1 loads
//   into the write bank.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   start_i, chunk_num_i         tile start pulse and chunk count
//   busy_o, done_o               tile in progress / readout complete pulse
//   ifm_valid_i, ifm_ready_o     IFM beat handshake
//   fil_valid_i, fil_ready_o     filter beat handshake
//   ifm_chunk_wr_*_o             IFM bank write strobe, beat index, bank
//   filter_chunk_wr_*_o          filter bank write strobe, beat index, bank,
//                                one-hot target CU
//   *_chunk_rd_sel_o             bank the cluster computes from
//   run_valid_o                  cluster compute enable
//   total_chunk_start_o          one-cycle chunk start
//   total_chunk_end_i            cluster chunk done
//   acc_buf_sel_o                accumulation buffer for this tile
//   com_unit_out_buf_sel_o       CU being read out
//   out_valid_o, out_ready_i     readout handshake
module compute_cluster_sequencer #(
    parameter int CU_NUM         = 4,
    parameter int WR_DAT_CYC_NUM = 4,
    parameter int OUTPUT_BUF_NUM = 4,
    parameter int CHUNK_CNT_W    = 16,
    localparam int CW = (WR_DAT_CYC_NUM > 1) ? $clog2(WR_DAT_CYC_NUM) : 1,
    localparam int AW = (OUTPUT_BUF_NUM > 1) ? $clog2(OUTPUT_BUF_NUM) : 1,
    localparam int SW = (CU_NUM > 1) ? $clog2(CU_NUM) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [CHUNK_CNT_W-1:0] chunk_num_i,
    output logic                   busy_o,
    output logic                   done_o,
    input  logic                   ifm_valid_i,
    output logic                   ifm_ready_o,
    input  logic                   fil_valid_i,
    output logic                   fil_ready_o,
    output logic                   ifm_chunk_wr_valid_o,
    output logic [CW-1:0]          ifm_chunk_wr_count_o,
    output logic                   ifm_chunk_wr_sel_o,
    output logic                   filter_chunk_wr_sel_o,
    output logic                   ifm_chunk_rd_sel_o,
    output logic                   filter_chunk_rd_sel_o,
    output logic                   filter_chunk_wr_valid_o,
    output logic [CW-1:0]          filter_chunk_wr_count_o,
    output logic [CU_NUM-1:0]      filter_chunk_cu_wr_sel_o,
    output logic                   run_valid_o,
    output logic                   total_chunk_start_o,
    input  logic                   total_chunk_end_i,
    output logic [AW-1:0]          acc_buf_sel_o,
    output logic [SW-1:0]          com_unit_out_buf_sel_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i
);

    typedef enum logic [1:0] {L_IDLE, L_IFM, L_FIL} lstate_e;
    typedef enum logic [2:0] {C_IDLE, C_WAIT, C_START, C_RUN, C_OUT} cstate_e;

    localparam logic [CW-1:0]          BEAT_LAST = CW'(WR_DAT_CYC_NUM - 1);
    localparam logic [SW-1:0]          CU_LAST   = SW'(CU_NUM - 1);
    localparam logic [AW-1:0]          ACC_LAST  = AW'(OUTPUT_BUF_NUM - 1);
    localparam logic [CHUNK_CNT_W-1:0] CNT_ONE   = CHUNK_CNT_W'(1);

    lstate_e                lstate_q, lstate_d;
    cstate_e                cstate_q, cstate_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [CHUNK_CNT_W-1:0] chunk_num_q, chunk_num_d;
    logic [CHUNK_CNT_W-1:0] loaded_q, loaded_d;
    logic [CHUNK_CNT_W-1:0] computed_q, computed_d;
    logic                   wr_bank_q, wr_bank_d;
    logic                   rd_bank_q, rd_bank_d;
    logic [1:0]             full_q, full_d;
    logic [CW-1:0]          ifm_cnt_q, ifm_cnt_d;
    logic [CW-1:0]          fil_cnt_q, fil_cnt_d;
    logic [SW-1:0]          cu_idx_q, cu_idx_d;
    logic [SW-1:0]          out_sel_q, out_sel_d;
    logic [AW-1:0]          acc_q, acc_d;

    logic                   ifm_hs, fil_hs;
    logic [CHUNK_CNT_W-1:0] loaded_inc, computed_inc;

    // A write bank still holding an uncomputed chunk stalls the IFM stream.
    assign ifm_ready_o = (lstate_q == L_IFM) && !full_q[wr_bank_q];
    assign fil_ready_o = (lstate_q == L_FIL);
    assign ifm_hs      = ifm_valid_i && ifm_ready_o;
    assign fil_hs      = fil_valid_i && fil_ready_o;

    assign loaded_inc   = loaded_q + CNT_ONE;
    assign computed_inc = computed_q + CNT_ONE;

    assign busy_o                   = busy_q;
    assign done_o                   = done_q;
    assign ifm_chunk_wr_valid_o     = ifm_hs;
    assign ifm_chunk_wr_count_o     = ifm_cnt_q;
    assign ifm_chunk_wr_sel_o       = wr_bank_q;
    assign filter_chunk_wr_sel_o    = wr_bank_q;
    assign ifm_chunk_rd_sel_o       = rd_bank_q;
    assign filter_chunk_rd_sel_o    = rd_bank_q;
    assign filter_chunk_wr_valid_o  = fil_hs;
    assign filter_chunk_wr_count_o  = fil_cnt_q;
    // CU select only meaningful while filter beats flow; kept at 0 otherwise.
    assign filter_chunk_cu_wr_sel_o = (lstate_q == L_FIL) ? (CU_NUM'(1) << cu_idx_q) : '0;
    assign run_valid_o              = (cstate_q == C_START) || (cstate_q == C_RUN);
    assign total_chunk_start_o      = (cstate_q == C_START);
    assign acc_buf_sel_o            = acc_q;
    assign com_unit_out_buf_sel_o   = out_sel_q;
    assign out_valid_o              = (cstate_q == C_OUT);

    always_comb begin
        lstate_d    = lstate_q;
        cstate_d    = cstate_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        chunk_num_d = chunk_num_q;
        loaded_d    = loaded_q;
        computed_d  = computed_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        full_d      = full_q;
        ifm_cnt_d   = ifm_cnt_q;
        fil_cnt_d   = fil_cnt_q;
        cu_idx_d    = cu_idx_q;
        out_sel_d   = out_sel_q;
        acc_d       = acc_q;

        if (start_i && !busy_q && (chunk_num_i != '0)) begin
            busy_d      = 1'b1;
            chunk_num_d = chunk_num_i;
            loaded_d    = '0;
            computed_d  = '0;
        end

        case (lstate_q)
            L_IDLE: begin
                if (busy_q && (loaded_q < chunk_num_q) && !full_q[wr_bank_q])
                    lstate_d = L_IFM;
            end
            L_IFM: begin
                if (ifm_hs) begin
                    if (ifm_cnt_q == BEAT_LAST) begin
                        ifm_cnt_d = '0;
                        lstate_d  = L_FIL;
                    end else begin
                        ifm_cnt_d = ifm_cnt_q + CW'(1);
                    end
                end
            end
            L_FIL: begin
                if (fil_hs) begin
                    if (fil_cnt_q == BEAT_LAST) begin
                        fil_cnt_d = '0;
                        if (cu_idx_q == CU_LAST) begin
                            // Chunk complete: hand the bank to compute.
                            cu_idx_d          = '0;
                            full_d[wr_bank_q] = 1'b1;
                            wr_bank_d         = !wr_bank_q;
                            loaded_d          = loaded_inc;
                            lstate_d          = (loaded_inc < chunk_num_q) ? L_IFM : L_IDLE;
                        end else begin
                            cu_idx_d = cu_idx_q + SW'(1);
                        end
                    end else begin
                        fil_cnt_d = fil_cnt_q + CW'(1);
                    end
                end
            end
            default: lstate_d = L_IDLE;
        endcase

        case (cstate_q)
            C_IDLE:  if (busy_q) cstate_d = C_WAIT;
            C_WAIT:  if (full_q[rd_bank_q]) cstate_d = C_START;
            C_START: cstate_d = C_RUN;
            C_RUN: begin
                if (total_chunk_end_i) begin
                    // Clear targets rd_bank, set targets wr_bank; never the same bank.
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = !rd_bank_q;
                    computed_d        = computed_inc;
                    cstate_d          = (computed_inc == chunk_num_q) ? C_OUT : C_WAIT;
                end
            end
            C_OUT: begin
                if (out_ready_i) begin
                    if (out_sel_q == CU_LAST) begin
                        out_sel_d = '0;
                        cstate_d  = C_IDLE;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        acc_d     = (acc_q == ACC_LAST) ? '0 : acc_q + AW'(1);
                        wr_bank_d = 1'b0;
                        rd_bank_d = 1'b0;
                    end else begin
                        out_sel_d = out_sel_q + SW'(1);
                    end
                end
            end
            default: cstate_d = C_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lstate_q    <= L_IDLE;
            cstate_q    <= C_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            chunk_num_q <= '0;
            loaded_q    <= '0;
            computed_q  <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= '0;
            ifm_cnt_q   <= '0;
            fil_cnt_q   <= '0;
            cu_idx_q    <= '0;
            out_sel_q   <= '0;
            acc_q       <= '0;
        end else begin
            lstate_q    <= lstate_d;
            cstate_q    <= cstate_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            chunk_num_q <= chunk_num_d;
            loaded_q    <= loaded_d;
            computed_q  <= computed_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            ifm_cnt_q   <= ifm_cnt_d;
            fil_cnt_q   <= fil_cnt_d;
            cu_idx_q    <= cu_idx_d;
            out_sel_q   <= out_sel_d;
            acc_q       <= acc_d;
        end
    end

endmodule

// File: tb/tb_compute_cluster_sequencer.sv
`timescale 1ns/1ps
module tb_compute_cluster_sequencer;
    localparam int CU  = 4;
    localparam int WR  = 4;
    localparam int OB  = 4;
    localparam int CCW = 16;

    logic           clk = 1'b0;
    logic           rst_i, start_i;
    logic [CCW-1:0] chunk_num_i;
    logic           busy_o, done_o;
    logic           ifm_valid_i, ifm_ready_o, fil_valid_i, fil_ready_o;
    logic           ifm_chunk_wr_valid_o;
    logic [1:0]     ifm_chunk_wr_count_o;
    logic           ifm_chunk_wr_sel_o, filter_chunk_wr_sel_o;
    logic           ifm_chunk_rd_sel_o, filter_chunk_rd_sel_o;
    logic           filter_chunk_wr_valid_o;
    logic [1:0]     filter_chunk_wr_count_o;
    logic [CU-1:0]  filter_chunk_cu_wr_sel_o;
    logic           run_valid_o, total_chunk_start_o, total_chunk_end_i;
    logic [1:0]     acc_buf_sel_o, com_unit_out_buf_sel_o;
    logic           out_valid_o, out_ready_i;

    always #5 clk = ~clk;

    compute_cluster_sequencer #(.CU_NUM(CU), .WR_DAT_CYC_NUM(WR),
                                .OUTPUT_BUF_NUM(OB), .CHUNK_CNT_W(CCW)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .chunk_num_i(chunk_num_i),
        .busy_o(busy_o), .done_o(done_o),
        .ifm_valid_i(ifm_valid_i), .ifm_ready_o(ifm_ready_o),
        .fil_valid_i(fil_valid_i), .fil_ready_o(fil_ready_o),
        .ifm_chunk_wr_valid_o(ifm_chunk_wr_valid_o),
        .ifm_chunk_wr_count_o(ifm_chunk_wr_count_o),
        .ifm_chunk_wr_sel_o(ifm_chunk_wr_sel_o),
        .filter_chunk_wr_sel_o(filter_chunk_wr_sel_o),
        .ifm_chunk_rd_sel_o(ifm_chunk_rd_sel_o),
        .filter_chunk_rd_sel_o(filter_chunk_rd_sel_o),
        .filter_chunk_wr_valid_o(filter_chunk_wr_valid_o),
        .filter_chunk_wr_count_o(filter_chunk_wr_count_o),
        .filter_chunk_cu_wr_sel_o(filter_chunk_cu_wr_sel_o),
        .run_valid_o(run_valid_o), .total_chunk_start_o(total_chunk_start_o),
        .total_chunk_end_i(total_chunk_end_i),
        .acc_buf_sel_o(acc_buf_sel_o),
        .com_unit_out_buf_sel_o(com_unit_out_buf_sel_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Expected-event scoreboards, filled when a tile is issued.
    int exp_ifm[$];    // bank*16 + beat
    int exp_fil[$];    // last<<12 | bank<<8 | beat<<4 | cu one-hot
    int exp_start[$];  // read bank
    int exp_out[$];    // readout CU index
    int exp_acc[$];    // acc buffer after the tile
    int fill_q[$];     // cycle of each chunk's last filter beat

    // Stimulus knobs.
    bit src_rand  = 0;
    int or_mode   = 0;  // 0 always ready, 1 random, 2 five-cycle stall at sel 2
    int stall_cnt = 0;
    int end_delay = 3;
    int acc_model = 0;

    // Monitor-side state.
    bit       in_run = 0, pend_end = 0, pend_done = 0, prev_stall = 0;
    bit [1:0] mfull = '0;
    int       end_at = 0, run_bank = 0, prev_sel = 0, last_end = -100;
    int       starts_seen = 0, tiles_done = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Source / sink driver.
    initial begin
        ifm_valid_i = 1'b0; fil_valid_i = 1'b0;
        total_chunk_end_i = 1'b0; out_ready_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            ifm_valid_i = src_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
            fil_valid_i = src_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
            total_chunk_end_i = pend_end && (cyc >= end_at);
            if (or_mode == 1)
                out_ready_i = ($urandom_range(0, 1) == 1);
            else if (or_mode == 2 && out_valid_o && com_unit_out_buf_sel_o == 2'd2 && stall_cnt < 5) begin
                out_ready_i = 1'b0;
                stall_cnt++;
            end else
                out_ready_i = 1'b1;
        end
    end

    // Monitor: pops the scoreboards whenever the DUT presents an event.
    always @(negedge clk) begin
        int e, b, f, ex, nxt_done;
        if (rst_i) begin
            exp_ifm.delete(); exp_fil.delete(); exp_start.delete();
            exp_out.delete(); exp_acc.delete(); fill_q.delete();
            in_run = 0; pend_end = 0; pend_done = 0; prev_stall = 0; mfull = '0;
        end else begin
            nxt_done = 0;
            if (prev_stall) begin
                chk("out_hold_valid", int'(out_valid_o), 1);
                chk("out_hold_sel", int'(com_unit_out_buf_sel_o), prev_sel);
            end
            prev_stall = out_valid_o && !out_ready_i;
            prev_sel   = int'(com_unit_out_buf_sel_o);

            if (mfull == 2'b11) chk("ifm_ready_both_full", int'(ifm_ready_o), 0);

            if (ifm_chunk_wr_valid_o) begin
                chk("ifm_wr_to_full_bank", int'(mfull[ifm_chunk_wr_sel_o]), 0);
                if (exp_ifm.size() == 0) chk("ifm_unexpected", 1, 0);
                else begin
                    e = exp_ifm.pop_front();
                    chk("ifm_beat", int'(ifm_chunk_wr_sel_o) * 16 + int'(ifm_chunk_wr_count_o), e);
                end
            end

            if (filter_chunk_wr_valid_o) begin
                chk("fil_wr_to_full_bank", int'(mfull[filter_chunk_wr_sel_o]), 0);
                if (exp_fil.size() == 0) chk("fil_unexpected", 1, 0);
                else begin
                    e = exp_fil.pop_front();
                    chk("fil_beat", int'(filter_chunk_wr_sel_o) * 256 + int'(filter_chunk_wr_count_o) * 16
                        + int'(filter_chunk_cu_wr_sel_o), e & 'hFFF);
                    if (e >= 'h1000) begin
                        fill_q.push_back(cyc);
                        mfull[(e >> 8) & 1] = 1'b1;
                    end
                end
            end

            if (total_chunk_start_o) begin
                chk("start_run_valid", int'(run_valid_o), 1);
                if (exp_start.size() == 0 || fill_q.size() == 0) chk("start_unexpected", 1, 0);
                else begin
                    b = exp_start.pop_front();
                    f = fill_q.pop_front();
                    run_bank = b;
                    chk("start_rd_bank", int'(ifm_chunk_rd_sel_o) * 2 + int'(filter_chunk_rd_sel_o), b * 3);
                    ex = (f + 2 > last_end + 2) ? f + 2 : last_end + 2;
                    chk("start_latency", cyc, ex);
                end
                in_run = 1; pend_end = 1; end_at = cyc + end_delay; starts_seen++;
            end

            if (total_chunk_end_i && in_run) begin
                chk("end_in_run", int'(run_valid_o), 1);
                mfull[run_bank] = 1'b0;
                last_end = cyc; in_run = 0; pend_end = 0;
            end

            if (out_valid_o && out_ready_i) begin
                if (exp_out.size() == 0) chk("out_unexpected", 1, 0);
                else begin
                    e = exp_out.pop_front();
                    chk("out_sel", int'(com_unit_out_buf_sel_o), e);
                    if (e == CU - 1) nxt_done = 1;
                end
            end

            if (pend_done || done_o) begin
                chk("done_pulse", int'(done_o), int'(pend_done));
                if (pend_done) begin
                    chk("done_busy_clear", int'(busy_o), 0);
                    if (exp_acc.size() == 0) chk("acc_unexpected", 1, 0);
                    else chk("acc_buf_sel", int'(acc_buf_sel_o), exp_acc.pop_front());
                    tiles_done++;
                end
            end
            pend_done = (nxt_done != 0);
        end
    end

    task automatic check_zero(input string name);
        logic [31:0] v;
        v = 32'({busy_o, done_o, ifm_ready_o, fil_ready_o, ifm_chunk_wr_valid_o,
                 ifm_chunk_wr_count_o, ifm_chunk_wr_sel_o, filter_chunk_wr_sel_o,
                 ifm_chunk_rd_sel_o, filter_chunk_rd_sel_o, filter_chunk_wr_valid_o,
                 filter_chunk_wr_count_o, filter_chunk_cu_wr_sel_o, run_valid_o,
                 total_chunk_start_o, acc_buf_sel_o, com_unit_out_buf_sel_o, out_valid_o});
        chk(name, int'(v), 0);
    endtask

    // Expected behaviour of a whole tile: chunk k lives in bank k%2, IFM beats
    // 0..WR-1, then WR beats per CU in CU order, one start per chunk, readout
    // of every CU, and the accumulation buffer advances by one.
    task automatic begin_tile(input int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < WR; i++) exp_ifm.push_back((k % 2) * 16 + i);
            for (int c = 0; c < CU; c++)
                for (int bt = 0; bt < WR; bt++)
                    exp_fil.push_back(((c == CU - 1 && bt == WR - 1) ? 'h1000 : 0)
                                      + (k % 2) * 256 + bt * 16 + (1 << c));
            exp_start.push_back(k % 2);
        end
        for (int s = 0; s < CU; s++) exp_out.push_back(s);
        acc_model = (acc_model + 1) % OB;
        exp_acc.push_back(acc_model);
        stall_cnt = 0;
        @(posedge clk); #1;
        start_i = 1'b1; chunk_num_i = CCW'(n);
        @(posedge clk); #1;
        start_i = 1'b0; chunk_num_i = '0;
    endtask

    task automatic wait_tile(input int limit);
        int d0, k;
        d0 = tiles_done; k = 0;
        while (tiles_done == d0 && k < limit) begin @(negedge clk); k++; end
        if (tiles_done == d0) chk("tile_timeout", 0, 1);
        @(negedge clk);
        chk("scoreboard_drained", exp_ifm.size() + exp_fil.size() + exp_start.size()
            + exp_out.size() + exp_acc.size(), 0);
    endtask

    initial begin
        int s0, k;
        rst_i = 1'b1; start_i = 1'b0; chunk_num_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        check_zero("reset_outputs");

        // Single chunk, always-valid sources.
        end_delay = 3; begin_tile(1); wait_tile(2000);
        // Three chunks with long compute: overlap and both-banks-full stall.
        end_delay = 40; begin_tile(3); wait_tile(2000);
        // Four chunks with fast compute.
        end_delay = 2; begin_tile(4); wait_tile(2000);
        // Readout stall at sel 2, plus a start while busy that must be ignored.
        or_mode = 2; end_delay = 5; begin_tile(2);
        repeat (5) @(negedge clk);
        chk("busy_during_tile", int'(busy_o), 1);
        @(posedge clk); #1 start_i = 1'b1; chunk_num_i = 16'd3;
        @(posedge clk); #1 start_i = 1'b0; chunk_num_i = '0;
        wait_tile(2000);
        // Zero-chunk start is ignored.
        @(posedge clk); #1 start_i = 1'b1; chunk_num_i = '0;
        @(posedge clk); #1 start_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("zero_chunk_ignored", int'(busy_o), 0);

        // Randomized tiles.
        src_rand = 1; or_mode = 1;
        for (int t = 0; t < 4; t++) begin
            end_delay = $urandom_range(1, 30);
            begin_tile($urandom_range(1, 5));
            wait_tile(4000);
        end

        // Reset in the middle of compute and load.
        src_rand = 0; or_mode = 0; end_delay = 40;
        s0 = starts_seen; begin_tile(3);
        k = 0;
        while (starts_seen == s0 && k < 500) begin @(negedge clk); k++; end
        if (starts_seen == s0) chk("first_start_timeout", 0, 1);
        repeat (10) @(posedge clk);
        #1 rst_i = 1'b1;
        @(posedge clk); #1 rst_i = 1'b0;
        acc_model = 0;
        @(negedge clk);
        check_zero("post_reset_outputs");
        repeat (20) begin
            @(negedge clk);
            chk("no_done_after_reset", int'(done_o), 0);
        end
        // Clean tile after the abort.
        end_delay = 4; begin_tile(2); wait_tile(2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
